// File: rtl/boton_sensor_ar.sv
// Debounce filter: MODE=0 one-shot button pulse, MODE=1 symmetric sensor level filter.
// Define BOTON_SENSOR_AR_SYNC_EN to put a 2-flop synchronizer in front of the filter.
module boton_sensor_ar #(
    parameter int   N       = 10000,
    parameter int   MODE    = 0,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_tmp,
    input  logic din,
    output logic dout
);

    // Widened before the +1 so N = 2^31-1 does not overflow the int.
    localparam int              CW       = $clog2(64'(N) + 64'd1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
    localparam logic            INIT     = (MODE == 1) ? RST_VAL : 1'b0;

    logic s;

`ifdef BOTON_SENSOR_AR_SYNC_EN
    logic [1:0] sync_pipe = {2{INIT}};

    always_ff @(posedge clk or negedge reset_tmp) begin
        if (!reset_tmp) sync_pipe <= {2{INIT}};
        else            sync_pipe <= {sync_pipe[0], din};
    end

    assign s = sync_pipe[1];
`else
    assign s = din;
`endif

    // Declaration initializers give a defined state when reset_tmp is tied high.
    logic [CW-1:0] cnt    = '0;
    logic          dout_q = INIT;
    logic          armed  = 1'b1;

    logic [CW-1:0] cnt_nxt;
    logic          dout_nxt;
    logic          armed_nxt;
    logic          cnt_hit;

    // cnt clears on the hit, so it never goes past N-1 and cannot wrap.
    assign cnt_hit = (cnt >= CNT_LAST);

    always_comb begin
        cnt_nxt   = '0;
        dout_nxt  = dout_q;
        armed_nxt = armed;
        if (MODE == 0) begin
            dout_nxt = 1'b0;
            if (!s) begin
                armed_nxt = 1'b1;
            end else if (armed) begin
                if (cnt_hit) begin
                    dout_nxt  = 1'b1;
                    armed_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        end else begin
            if (s != dout_q) begin
                if (cnt_hit) dout_nxt = s;
                else         cnt_nxt  = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_tmp) begin
        if (!reset_tmp) begin
            cnt    <= '0;
            dout_q <= INIT;
            armed  <= 1'b1;
        end else begin
            cnt    <= cnt_nxt;
            dout_q <= dout_nxt;
            armed  <= armed_nxt;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_boton_sensor_ar.sv
// Directed bench for boton_sensor_ar: button and sensor instances, table vectors plus reset sequences.
module tb_boton_sensor_ar;

`ifdef BOTON_SENSOR_AR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int NB = 4;
    localparam int NS = 4;
    localparam int N8 = 8;

    logic clk = 1'b0;
    logic rst_n, rst8;
    logic din_b4, din_s4, din_b8, din_s1;
    logic dout_b4, dout_s4, dout_b8, dout_s1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   dut;
        logic din;
        logic exp;
    } vec_t;

    vec_t vecs[$];

    boton_sensor_ar #(.N(NB), .MODE(0), .RST_VAL(1'b0)) u_b4 (
        .clk(clk), .reset_tmp(rst_n), .din(din_b4), .dout(dout_b4));
    boton_sensor_ar #(.N(NS), .MODE(1), .RST_VAL(1'b0)) u_s4 (
        .clk(clk), .reset_tmp(rst_n), .din(din_s4), .dout(dout_s4));
    boton_sensor_ar #(.N(N8), .MODE(0), .RST_VAL(1'b0)) u_b8 (
        .clk(clk), .reset_tmp(rst8), .din(din_b8), .dout(dout_b8));
    boton_sensor_ar #(.N(NS), .MODE(1), .RST_VAL(1'b1)) u_s1 (
        .clk(clk), .reset_tmp(1'b1), .din(din_s1), .dout(dout_s1));

    always #5 clk = ~clk;

    task automatic add(input int d, input logic di, input logic ex);
        vec_t v;
        v.dut = d;
        v.din = di;
        v.exp = ex;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic act;

        // Button N=4: long hold -> one pulse at edge NB+LAT, then release.
        for (int i = 1; i <= 20; i++) add(0, 1'b1, i == NB + LAT);
        for (int i = 1; i <= 6; i++)  add(0, 1'b0, 1'b0);
        // Button bounce: 3 high / 1 low, five times, never pulses.
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 3; i++) add(0, 1'b1, 1'b0);
            add(0, 1'b0, 1'b0);
        end
        for (int i = 1; i <= 6; i++)  add(0, 1'b0, 1'b0);
        // Sensor N=4: rising step, falling step.
        for (int i = 1; i <= 10; i++) add(1, 1'b1, i >= NS + LAT);
        for (int i = 1; i <= 10; i++) add(1, 1'b0, i < NS + LAT);
        // Sensor glitch of N-1 samples is swallowed.
        for (int i = 0; i < 3; i++)   add(1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)   add(1, 1'b0, 1'b0);
        // Sensor pulse of exactly N samples: up at NS+LAT, down 4 edges later.
        for (int i = 1; i <= 14; i++)
            add(1, i <= 4, (i >= NS + LAT) && (i <= NS + 3 + LAT));
        // Tied-reset sensor with RST_VAL=1: stays 1, then falls after a held low.
        for (int i = 1; i <= 3; i++)  add(2, 1'b1, 1'b1);
        for (int i = 1; i <= NS + 2; i++) add(2, 1'b0, i < NS + LAT);

        din_b4 = 1'b0;
        din_s4 = 1'b0;
        din_b8 = 1'b0;
        din_s1 = 1'b1;
        rst_n  = 1'b0;
        rst8   = 1'b0;
        #1;
        chk("pwr_s1", dout_s1, 1'b1);
        chk("rst_b4", dout_b4, 1'b0);
        chk("rst_s4", dout_s4, 1'b0);
        chk("rst_b8", dout_b8, 1'b0);
        tick();
        chk("pwr_s1_e1", dout_s1, 1'b1);
        tick();
        rst_n = 1'b1;
        rst8  = 1'b1;
        for (int i = 0; i < LAT + 2; i++) tick();

        foreach (vecs[i]) begin
            case (vecs[i].dut)
                0:       din_b4 = vecs[i].din;
                1:       din_s4 = vecs[i].din;
                default: din_s1 = vecs[i].din;
            endcase
            tick();
            case (vecs[i].dut)
                0:       act = dout_b4;
                1:       act = dout_s4;
                default: act = dout_s1;
            endcase
            chk($sformatf("vec%0d_dut%0d", i, vecs[i].dut), act, vecs[i].exp);
        end

        // Async reset drops the sensor output with no clock edge.
        din_s4 = 1'b1;
        for (int i = 0; i < NS + LAT; i++) tick();
        chk("s4_hi_before_rst", dout_s4, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("s4_async_rst", dout_s4, 1'b0);
        tick();
        din_s4 = 1'b0;
        rst_n  = 1'b1;
        tick();
        chk("s4_after_rst", dout_s4, 1'b0);

        // Button N=8: reset mid-count restarts the filter from zero.
        din_b8 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("b8_pre%0d", k), dout_b8, 1'b0);
        end
        rst8 = 1'b0;
        #1;
        chk("b8_in_rst", dout_b8, 1'b0);
        tick();
        rst8 = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            chk($sformatf("b8_post%0d", k), dout_b8, k == N8 + LAT);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
